// File: rtl/sdc_pkg.sv
// Shared types and constants for the SD card DAT0 block path.
// Used by both the reader and writer sides.
package sdc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_DATA,
    ST_CRC,
    ST_ENDBIT
  } sdc_state_e;

  localparam logic [15:0] CRC16_POLY       = 16'h1021;
  localparam int          DEF_BLOCK_BYTES  = 512;
  localparam logic [15:0] DEF_TIMEOUT_BITS = 16'hFFFF;
  localparam logic        START_BIT        = 1'b0;
  localparam logic        END_BIT          = 1'b1;

  function automatic logic [15:0] crc16_step(
    input logic [15:0] crc,
    input logic        b
  );
    logic fb;
    fb = b ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/sdc_crc16.sv
// Serial CRC16 (x^16+x^12+x^5+1), one bit per enabled clock.
// Initial value zero; clear has priority over enable.
module sdc_crc16
  import sdc_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic        clear,
  input  logic        enable,
  input  logic        bitIn,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = '0;
    end else if (enable) begin
      crc_d = crc16_step(crc_q, bitIn);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sdc_read_block.sv
// Receives one SD data block on DAT0: start bit, data bytes,
// CRC16 and end bit, delivering bytes MSB first as they complete.
module sdc_read_block
  import sdc_pkg::*;
#(
  parameter int          BLOCK_BYTES  = DEF_BLOCK_BYTES,
  parameter logic [15:0] TIMEOUT_BITS = DEF_TIMEOUT_BITS
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       bitEn,
  input  logic       dat0,
  input  logic       start,
  output logic [7:0] byteOut,
  output logic       byteValid,
  output logic       blockDone,
  output logic       crcOk,
  output logic       crcErr,
  output logic       timeout,
  output logic       busy
);

  localparam logic [15:0] LAST_DATA = 16'(BLOCK_BYTES * 8 - 1);
  localparam logic [15:0] LAST_CRC  = 16'(BLOCK_BYTES * 8 + 15);

  sdc_state_e  state_q, state_d;
  logic [15:0] bit_cnt_q, bit_cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic [15:0] rx_crc_q, rx_crc_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        bvalid_q, bvalid_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic        tmo_flag_q, tmo_flag_d;
  logic        crc_clear;
  logic        crc_en;
  logic [15:0] crc_calc;

  sdc_crc16 u_crc (
    .clk    (clk),
    .resetN (resetN),
    .clear  (crc_clear),
    .enable (crc_en),
    .bitIn  (dat0),
    .crc    (crc_calc)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_WAIT_START;
      end
      ST_WAIT_START: begin
        if (bitEn) begin
          if (dat0 == START_BIT) state_d = ST_DATA;
          else if (tmo_q <= 16'd1) state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (bitEn && bit_cnt_q == LAST_DATA) state_d = ST_CRC;
      end
      ST_CRC: begin
        if (bitEn && bit_cnt_q == LAST_CRC) state_d = ST_ENDBIT;
      end
      ST_ENDBIT: begin
        if (bitEn) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    tmo_d      = tmo_q;
    rx_crc_d   = rx_crc_q;
    shift_d    = shift_q;
    byte_d     = byte_q;
    bvalid_d   = 1'b0;
    done_d     = 1'b0;
    ok_d       = ok_q;
    err_d      = err_q;
    tmo_flag_d = tmo_flag_q;
    crc_clear  = 1'b0;
    crc_en     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ok_d       = 1'b0;
          err_d      = 1'b0;
          tmo_flag_d = 1'b0;
          rx_crc_d   = '0;
          tmo_d      = TIMEOUT_BITS;
          crc_clear  = 1'b1;
        end
      end
      ST_WAIT_START: begin
        if (bitEn) begin
          if (dat0 == START_BIT) begin
            bit_cnt_d = '0;
          end else begin
            if (tmo_q != 16'd0) tmo_d = tmo_q - 16'd1;
            if (tmo_q <= 16'd1) begin
              tmo_flag_d = 1'b1;
              done_d     = 1'b1;
            end
          end
        end
      end
      ST_DATA: begin
        if (bitEn) begin
          shift_d   = {shift_q[6:0], dat0};
          bit_cnt_d = bit_cnt_q + 16'd1;
          crc_en    = 1'b1;
          // Low three count bits == 7 means this sample closes a byte
          if (bit_cnt_q[2:0] == 3'd7) begin
            byte_d   = {shift_q[6:0], dat0};
            bvalid_d = 1'b1;
          end
        end
      end
      ST_CRC: begin
        if (bitEn) begin
          rx_crc_d  = {rx_crc_q[14:0], dat0};
          bit_cnt_d = bit_cnt_q + 16'd1;
        end
      end
      ST_ENDBIT: begin
        if (bitEn) begin
          done_d = 1'b1;
          if (rx_crc_q == crc_calc && dat0 == END_BIT) ok_d = 1'b1;
          else err_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bit_cnt_q  <= '0;
      tmo_q      <= '0;
      rx_crc_q   <= '0;
      shift_q    <= '0;
      byte_q     <= '0;
      bvalid_q   <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 1'b0;
      tmo_flag_q <= 1'b0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      tmo_q      <= tmo_d;
      rx_crc_q   <= rx_crc_d;
      shift_q    <= shift_d;
      byte_q     <= byte_d;
      bvalid_q   <= bvalid_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      err_q      <= err_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign byteOut   = byte_q;
  assign byteValid = bvalid_q;
  assign blockDone = done_q;
  assign crcOk     = ok_q;
  assign crcErr    = err_q;
  assign timeout   = tmo_flag_q;

endmodule

// File: tb/tb_sdc_read_block.sv
// Scoreboard bench for sdc_read_block: stimulus queues expected
// bytes and block results, a negedge monitor pops and compares.
module tb_sdc_read_block;

  localparam int BB = 512;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       bitEn = 1'b0;
  logic       dat0 = 1'b1;
  logic       start = 1'b0;
  logic [7:0] byteOut;
  logic       byteValid;
  logic       blockDone;
  logic       crcOk;
  logic       crcErr;
  logic       timeout;
  logic       busy;

  always #5 clk = ~clk;

  sdc_read_block #(
    .BLOCK_BYTES  (BB),
    .TIMEOUT_BITS (16'd16)
  ) dut (
    .clk       (clk),
    .resetN    (resetN),
    .bitEn     (bitEn),
    .dat0      (dat0),
    .start     (start),
    .byteOut   (byteOut),
    .byteValid (byteValid),
    .blockDone (blockDone),
    .crcOk     (crcOk),
    .crcErr    (crcErr),
    .timeout   (timeout),
    .busy      (busy)
  );

  typedef struct packed {
    logic ok;
    logic err;
    logic tmo;
  } done_t;

  logic [7:0] exp_bytes[$];
  done_t      exp_done[$];
  int         checks = 0;
  int         passed = 0;
  int         since = 0;
  logic       prev_en = 1'b0;

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  function automatic logic [15:0] crc_of(input logic [7:0] fill);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int i = 0; i < BB; i++) begin
      for (int b = 7; b >= 0; b--) begin
        fb = fill[b] ^ c[15];
        c  = c << 1;
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  function automatic int gap(input int m);
    return (m == 0) ? 0 : int'($urandom_range(m, 1));
  endfunction

  always @(negedge clk) begin
    done_t d;
    if (byteValid) begin
      if (exp_bytes.size() == 0) check("unexpected_byte", 1, 0);
      else check("byte", byteOut, exp_bytes.pop_front());
      check("byte_after_biten", prev_en, 1);
      since = 0;
    end
    if (blockDone) begin
      if (exp_done.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        d = exp_done.pop_front();
        check("done_flags", {crcOk, crcErr, timeout}, d);
        check("done_busy", busy, 0);
        check("done_bytes_left", exp_bytes.size(), 0);
        if (!d.tmo) check("last_byte_to_done", since, 17);
      end
    end
    if (crcOk && crcErr) check("ok_err_exclusive", 1, 0);
    if (bitEn) since++;
    prev_en = bitEn;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int g);
    repeat (g) tick();
    bitEn = 1'b1;
    dat0  = b;
    tick();
    bitEn = 1'b0;
    dat0  = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset_check(input logic [7:0] last);
    repeat (3) tick();
    check("pre_reset_byte", byteOut, last);
    resetN = 1'b0;
    #1;
    check("reset_outputs",
          {byteOut, byteValid, blockDone, crcOk, crcErr, timeout, busy},
          0);
    repeat (3) tick();
    resetN = 1'b1;
    tick();
  endtask

  task automatic send_block(input logic [7:0] fill, input logic [15:0] crc,
                            input logic endb, input int idle, input int gm,
                            input int restart_at, input int abort_after);
    logic ok;
    pulse_start();
    repeat (idle) send_bit(1'b1, gap(gm));
    send_bit(1'b0, gap(gm));
    for (int i = 0; i < BB; i++) begin
      exp_bytes.push_back(fill);
      for (int b = 7; b >= 0; b--) send_bit(fill[b], gap(gm));
      if (i == restart_at) pulse_start();
      if (i + 1 == abort_after) begin
        do_reset_check(fill);
        return;
      end
    end
    for (int b = 15; b >= 0; b--) send_bit(crc[b], gap(gm));
    ok = (crc == crc_of(fill)) && endb;
    exp_done.push_back(done_t'{ok: ok, err: !ok, tmo: 1'b0});
    send_bit(endb, gap(gm));
    repeat (4) tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    check("reset_state",
          {byteOut, byteValid, blockDone, crcOk, crcErr, timeout, busy}, 0);
    resetN = 1'b1;
    tick();

    send_block(8'hFF, 16'h7FA1, 1'b1, 3, 0, -1, -1);
    repeat (10) tick();
    check("ok_held", {crcOk, crcErr, busy}, 3'b100);

    send_block(8'hFF, 16'h7FA0, 1'b1, 3, 0, -1, -1);
    check("crc_bad_held", {crcOk, crcErr}, 2'b01);

    send_block(8'hFF, 16'h7FA1, 1'b0, 3, 0, -1, -1);
    check("endbit_bad_held", {crcOk, crcErr}, 2'b01);

    pulse_start();
    check("start_clears", {crcOk, crcErr, timeout, busy}, 4'b0001);
    repeat (15) send_bit(1'b1, 0);
    check("pre_timeout", {timeout, busy}, 2'b01);
    exp_done.push_back(done_t'{ok: 1'b0, err: 1'b0, tmo: 1'b1});
    send_bit(1'b1, 0);
    repeat (5) tick();
    check("timeout_held", {timeout, busy}, 2'b10);

    send_block(8'h5A, crc_of(8'h5A), 1'b1, 15, 0, -1, -1);
    check("idle15_no_timeout", {crcOk, timeout}, 2'b10);

    send_block(8'hA5, crc_of(8'hA5), 1'b1, 3, 0, -1, 100);
    repeat (20) send_bit(1'b0, 0);
    repeat (5) tick();
    check("idle_after_reset", busy, 0);
    send_block(8'hA5, crc_of(8'hA5), 1'b1, 3, 0, -1, -1);
    check("after_reset_ok", {crcOk, crcErr}, 2'b10);

    send_block(8'hFF, 16'h7FA1, 1'b1, 3, 5, 9, -1);
    check("restart_ok", {crcOk, crcErr}, 2'b10);

    repeat (5) tick();
    check("bytes_drained", exp_bytes.size(), 0);
    check("done_drained", exp_done.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
